// File: rtl/alu_share_arbiter_pkg.sv
// Shared types and constants for the ALU sharing arbiter and its ALU.
package alu_share_arbiter_pkg;
  localparam int NUM_REQ_MIN = 2;
  localparam int NUM_REQ_MAX = 4;
  localparam int FUNCT_W     = 5;

  // funct3 encodings of the RV64I integer operations
  localparam logic [2:0] ALU_ADD_SUB = 3'b000;
  localparam logic [2:0] ALU_SLL     = 3'b001;
  localparam logic [2:0] ALU_SLT     = 3'b010;
  localparam logic [2:0] ALU_SLTU    = 3'b011;
  localparam logic [2:0] ALU_XOR     = 3'b100;
  localparam logic [2:0] ALU_SRL_SRA = 3'b101;
  localparam logic [2:0] ALU_OR      = 3'b110;
  localparam logic [2:0] ALU_AND     = 3'b111;

  typedef struct packed {
    logic [FUNCT_W-1:0] funct;
    logic [63:0]        a;
    logic [63:0]        b;
  } alu_req_t;
endpackage

// File: rtl/alu_complete.sv
// Combinational RV64I integer ALU; funct = {OP32, SUB/SRA, funct3}.
module alu_complete
  import alu_share_arbiter_pkg::*;
(
  input  logic [FUNCT_W-1:0] alu_funct,
  input  logic [63:0]        operand_a,
  input  logic [63:0]        operand_b,
  output logic [63:0]        result,
  output logic               result_eq_zero
);
  logic        op32;
  logic        alt;
  logic [2:0]  f3;
  logic [63:0] opa;
  logic [63:0] opb;
  logic [63:0] raw;
  logic [5:0]  shamt;

  assign op32 = alu_funct[4];
  assign alt  = alu_funct[3];
  assign f3   = alu_funct[2:0];

  always_comb begin
    // word ops run on sign-extended low halves; SRLW needs zero-extension instead
    opb = op32 ? {{32{operand_b[31]}}, operand_b[31:0]} : operand_b;
    if (op32 && (f3 == ALU_SRL_SRA) && !alt) opa = {32'b0, operand_a[31:0]};
    else if (op32)                            opa = {{32{operand_a[31]}}, operand_a[31:0]};
    else                                      opa = operand_a;
    shamt = op32 ? {1'b0, operand_b[4:0]} : operand_b[5:0];
    raw = '0;
    case (f3)
      ALU_ADD_SUB: raw = alt ? (opa - opb) : (opa + opb);
      ALU_SLL:     raw = opa << shamt;
      ALU_SLT:     raw = {63'b0, $signed(opa) < $signed(opb)};
      ALU_SLTU:    raw = {63'b0, opa < opb};
      ALU_XOR:     raw = opa ^ opb;
      ALU_SRL_SRA: begin
        if (alt) raw = $signed(opa) >>> shamt;
        else     raw = opa >> shamt;
      end
      ALU_OR:      raw = opa | opb;
      ALU_AND:     raw = opa & opb;
      default:     raw = '0;
    endcase
    result = op32 ? {{32{raw[31]}}, raw[31:0]} : raw;
  end

  assign result_eq_zero = (result == 64'd0);
endmodule

// File: rtl/alu_share_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first valid requester at or above rr_ptr.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req_valid,
  input  logic [PW-1:0] rr_ptr,
  input  logic          enable,
  output logic [N-1:0]  grant
);
  logic          found;
  logic [PW-1:0] idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = PW'((int'(rr_ptr) + k) % N);
      if (enable && !found && req_valid[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one alu_complete between NUM_REQ requesters with a single registered result slot.
// Define ALU_ARB_STATS_EN to add the stat_grants / stat_stalls counters.
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  parameter  int XLEN    = 64,
  localparam int IDW     = $clog2(NUM_REQ)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*FUNCT_W-1:0] req_funct,
  input  logic [NUM_REQ*XLEN-1:0]    req_operand_a,
  input  logic [NUM_REQ*XLEN-1:0]    req_operand_b,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [IDW-1:0]             rsp_id,
  output logic [XLEN-1:0]            rsp_result,
  output logic                       rsp_eq_zero
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [NUM_REQ*32-1:0]      stat_grants,
  output logic [31:0]                stat_stalls
`endif
);
  logic               slot_free;
  logic               accept;
  logic [NUM_REQ-1:0] grant;
  logic [IDW-1:0]     rr_ptr;
  logic [IDW-1:0]     gnt_idx;
  logic [IDW-1:0]     ptr_next;
  alu_req_t           sel;
  logic [63:0]        alu_result;
  logic               alu_eq_zero;

  assign slot_free = !rsp_valid || rsp_ready;

  rr_arbiter #(.N(NUM_REQ), .PW(IDW)) u_rr (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr),
    .enable    (slot_free && !flush),
    .grant     (grant)
  );

  assign req_ready = grant;
  assign accept    = |grant;

  // grant is one-hot, so an OR of the selected lanes is the mux
  always_comb begin
    sel     = '0;
    gnt_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        gnt_idx   = IDW'(i);
        sel.funct = req_funct[i*FUNCT_W +: FUNCT_W];
        sel.a     = req_operand_a[i*XLEN +: XLEN];
        sel.b     = req_operand_b[i*XLEN +: XLEN];
      end
    end
  end

  assign ptr_next = (gnt_idx == IDW'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;

  alu_complete u_alu (
    .alu_funct      (sel.funct),
    .operand_a      (sel.a),
    .operand_b      (sel.b),
    .result         (alu_result),
    .result_eq_zero (alu_eq_zero)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_result  <= '0;
      rsp_eq_zero <= 1'b0;
      rr_ptr      <= '0;
    end else if (accept) begin
      rsp_valid   <= 1'b1;
      rsp_id      <= gnt_idx;
      rsp_result  <= alu_result;
      rsp_eq_zero <= alu_eq_zero;
      rr_ptr      <= ptr_next;
    end else if (flush || rsp_ready) begin
      rsp_valid   <= 1'b0;
    end
  end

`ifdef ALU_ARB_STATS_EN
  logic [NUM_REQ-1:0][31:0] grant_cnt;
  logic [31:0]              stall_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      grant_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant[i]) grant_cnt[i] <= grant_cnt[i] + 32'd1;
      end
      if ((|req_valid) && !accept) stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign stat_grants = grant_cnt;
  assign stat_stalls = stall_cnt;
`endif
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed scenarios plus random traffic against a behavioural model.
module tb_alu_share_arbiter;
  localparam int N = 2;

  logic            clock;
  logic            reset;
  logic            flush;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*5-1:0]  req_funct;
  logic [N*64-1:0] req_operand_a;
  logic [N*64-1:0] req_operand_b;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [0:0]      rsp_id;
  logic [63:0]     rsp_result;
  logic            rsp_eq_zero;
`ifdef ALU_ARB_STATS_EN
  logic [N*32-1:0] stat_grants;
  logic [31:0]     stat_stalls;
`endif

  int checks = 0;
  int errors = 0;

  alu_share_arbiter #(.NUM_REQ(N)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_funct(req_funct),
    .req_operand_a(req_operand_a), .req_operand_b(req_operand_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_eq_zero(rsp_eq_zero)
`ifdef ALU_ARB_STATS_EN
    , .stat_grants(stat_grants), .stat_stalls(stat_stalls)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // RV64I reference in plain 32/64-bit arithmetic
  function automatic logic [63:0] alu_model(input logic [4:0] f, input logic [63:0] a, input logic [63:0] b);
    logic [31:0] a32, b32, r32;
    logic [63:0] r;
    a32 = a[31:0]; b32 = b[31:0]; r32 = '0; r = '0;
    if (f[4]) begin
      case (f[2:0])
        3'd0: r32 = f[3] ? a32 - b32 : a32 + b32;
        3'd1: r32 = a32 << b32[4:0];
        3'd2: r32 = {31'b0, $signed(a32) < $signed(b32)};
        3'd3: r32 = {31'b0, a32 < b32};
        3'd4: r32 = a32 ^ b32;
        3'd5: if (f[3]) r32 = $signed(a32) >>> b32[4:0]; else r32 = a32 >> b32[4:0];
        3'd6: r32 = a32 | b32;
        default: r32 = a32 & b32;
      endcase
      return {{32{r32[31]}}, r32};
    end
    case (f[2:0])
      3'd0: r = f[3] ? a - b : a + b;
      3'd1: r = a << b[5:0];
      3'd2: r = {63'b0, $signed(a) < $signed(b)};
      3'd3: r = {63'b0, a < b};
      3'd4: r = a ^ b;
      3'd5: if (f[3]) r = $signed(a) >>> b[5:0]; else r = a >> b[5:0];
      3'd6: r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  // model state
  logic        m_valid;
  int          m_id, m_ptr;
  logic [63:0] m_res;
  logic        m_eqz;
  int unsigned m_grants [N];
  int unsigned m_stalls;

  function automatic int model_grant();
    if ((m_valid && !rsp_ready) || flush) return -1;
    for (int k = 0; k < N; k++) begin
      if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  always @(posedge clock or posedge reset) begin : model
    int g;
    if (reset) begin
      m_valid = 1'b0; m_id = 0; m_ptr = 0; m_res = '0; m_eqz = 1'b0;
      for (int i = 0; i < N; i++) m_grants[i] = 0;
      m_stalls = 0;
    end else begin
      g = model_grant();
      if (g >= 0) begin
        m_res   = alu_model(req_funct[g*5 +: 5], req_operand_a[g*64 +: 64], req_operand_b[g*64 +: 64]);
        m_eqz   = (m_res == 64'd0);
        m_valid = 1'b1;
        m_id    = g;
        m_ptr   = (g + 1) % N;
        m_grants[g]++;
      end else if (flush || rsp_ready) begin
        m_valid = 1'b0;
      end
      if ((req_valid != 0) && (g < 0)) m_stalls++;
    end
  end

  always @(negedge clock) begin : compare
    int g;
    logic [N-1:0] exp_rdy;
    g = model_grant();
    exp_rdy = (g < 0) ? '0 : N'(1 << g);
    check("req_ready", req_ready, exp_rdy);
    check("rsp_valid", rsp_valid, m_valid);
    check("rsp_id", rsp_id, m_id[0:0]);
    check("rsp_result", rsp_result, m_res);
    check("rsp_eq_zero", rsp_eq_zero, m_eqz);
`ifdef ALU_ARB_STATS_EN
    for (int i = 0; i < N; i++) check("stat_grants", stat_grants[i*32 +: 32], m_grants[i]);
    check("stat_stalls", stat_stalls, m_stalls);
`endif
  end

  initial begin
    logic [63:0] cap_res;
    logic [N-1:0] hold;
`ifdef ALU_ARB_STATS_EN
    logic [31:0] s0;
`endif
    reset = 1'b1; flush = 1'b0; rsp_ready = 1'b1; req_valid = 2'b11;
    req_funct = {5'b01000, 5'b00000};
    req_operand_a = {64'd9, 64'd5};
    req_operand_b = {64'd9, 64'd7};
    repeat (2) @(posedge clock);
    @(negedge clock); reset = 1'b0;
    #1 check("reset_grant", req_ready, 2'b01);
    check("reset_rsp_valid", rsp_valid, 0);

    // first accept: r0 ADD, then r1 SUB
    @(posedge clock); #1;
    check("add_valid", rsp_valid, 1); check("add_id", rsp_id, 0);
    check("add_result", rsp_result, 12); check("add_eqz", rsp_eq_zero, 0);
    check("next_grant", req_ready, 2'b10);
    @(posedge clock); #1;
    check("sub_id", rsp_id, 1); check("sub_result", rsp_result, 0); check("sub_eqz", rsp_eq_zero, 1);

    // alternation with both valid
    for (int k = 0; k < 6; k++) begin
      @(posedge clock); #1;
      check("rr_valid", rsp_valid, 1);
      check("rr_id", rsp_id, k % 2);
    end

    // back-pressure with a full slot
    rsp_ready = 1'b0;
    #1 check("bp_ready", req_ready, 2'b00);
    cap_res = rsp_result;
`ifdef ALU_ARB_STATS_EN
    s0 = stat_stalls;
`endif
    repeat (3) begin
      @(posedge clock); #1;
      check("bp_hold_ready", req_ready, 2'b00);
      check("bp_hold_valid", rsp_valid, 1);
      check("bp_hold_id", rsp_id, 1);
      check("bp_hold_result", rsp_result, cap_res);
    end
`ifdef ALU_ARB_STATS_EN
    check("bp_stalls", stat_stalls - s0, 3);
`endif
    rsp_ready = 1'b1;
    #1 check("drain_grant", req_ready, 2'b01);
    @(posedge clock); #1;
    check("drain_valid", rsp_valid, 1); check("drain_id", rsp_id, 0);

    // flush beats a simultaneous request
    req_valid = 2'b01; flush = 1'b1;
    #1 check("flush_ready", req_ready, 2'b00);
    @(posedge clock); #1;
    check("flush_valid", rsp_valid, 0);
    flush = 1'b0;
    #1 check("post_flush_grant", req_ready, 2'b01);
    @(posedge clock); #1;
    check("post_flush_valid", rsp_valid, 1); check("post_flush_id", rsp_id, 0);

    // asynchronous reset between edges
    req_valid = 2'b11;
    @(posedge clock); #2;
    reset = 1'b1;
    #1 check("async_reset_valid", rsp_valid, 0);
`ifdef ALU_ARB_STATS_EN
    check("stats_cleared", stat_grants, 0);
`endif
    req_valid = 2'b01;
    @(negedge clock); reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
`ifdef ALU_ARB_STATS_EN
    check("stats_r0_three", stat_grants[31:0], 3);
`endif
    check("after_reset_id", rsp_id, 0);

    // random traffic; a pending payload is held until accepted
    for (int c = 0; c < 500; c++) begin
      @(negedge clock);
      hold = req_valid & ~req_ready;
      @(posedge clock); #1;
      for (int i = 0; i < N; i++) begin
        if (!hold[i]) begin
          req_valid[i] = 1'($urandom_range(0, 1));
          req_funct[i*5 +: 5] = 5'($urandom);
          case ($urandom_range(0, 3))
            0: begin
              req_operand_a[i*64 +: 64] = {$urandom, $urandom};
              req_operand_b[i*64 +: 64] = req_operand_a[i*64 +: 64];
            end
            1: begin
              req_operand_a[i*64 +: 64] = 64'($urandom_range(0, 15));
              req_operand_b[i*64 +: 64] = 64'($urandom_range(0, 15));
            end
            default: begin
              req_operand_a[i*64 +: 64] = {$urandom, $urandom};
              req_operand_b[i*64 +: 64] = {$urandom, $urandom};
            end
          endcase
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 9) == 0);
    end
    flush = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
